// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared parameters and types for the FFT bank controller
// Purpose: transform size, data width, tag FIFO depth and derived constants.
// Ports: none (package).
package fft_pkg;
  localparam int R        = 5;
  localparam int N        = 1 << R;
  localparam int W        = 16;
  localparam int TAG_D    = 4;
  localparam int AW       = R - 1;
  localparam int HALF     = N / 2;
  localparam int WB_TOTAL = R * N / 2;
  localparam int WBC_W    = $clog2(WB_TOTAL);
  localparam int TAG_W    = 2 * AW + 1;

  typedef logic [2*W-1:0] cplx_t;
  typedef logic [AW-1:0]  baddr_t;

  typedef struct packed {
    baddr_t a0;
    baddr_t a1;
    logic   sel;
  } tag_t;
endpackage

// File: rtl/fft_tag_fifo.sv
// rtl/fft_tag_fifo.sv - synchronous FIFO holding in-flight write-back tags
// Purpose: stores {a0,a1,sel} from issue until the butterfly result returns.
// Ports: i_clk/i_rst clock and sync active-high reset; push/push_data enqueue;
//   pop requests dequeue, pop_ok says it was honoured, pop_data is the head
//   (or the same-cycle push when empty); count/full/empty occupancy.
module fft_tag_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic                           pop_ok,
  output logic [WIDTH-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  // An empty FIFO can still serve a pop from the word being pushed this cycle.
  assign pop_ok   = pop && (!empty || push);
  assign do_push  = push && (!full || pop_ok);
  assign pop_data = empty ? push_data : mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(pop_ok);
    end
  end
endmodule

// File: rtl/fft_bank_ctrl.sv
// rtl/fft_bank_ctrl.sv - in-place FFT bank read/route/write-back controller
// Purpose: turns (a0,a1,sel_wing) triples into m0/m1 reads, routes the read
//   pair to the butterfly in wing order, writes results back in place, counts
//   write-backs and pulses o_done at the end of the R-pass transform.
// Ports: i_clk/i_rst clock and sync active-high reset; i_addr_vld/i_a0/i_a1/
//   i_sel_wing issue strobe; o_m*_re/o_m*_raddr/i_m*_rdata bank reads;
//   o_bf_vld/o_bf_x0/o_bf_x1 butterfly inputs; i_bf_vld/i_bf_y0/i_bf_y1
//   butterfly results; o_m*_we/o_m*_waddr/o_m*_wdata bank writes;
//   o_done completion pulse; o_ovf/o_unf sticky errors; o_idle nothing in flight.
module fft_bank_ctrl
  import fft_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_addr_vld,
  input  logic [AW-1:0] i_a0,
  input  logic [AW-1:0] i_a1,
  input  logic          i_sel_wing,
  output logic          o_m0_re,
  output logic [AW-1:0] o_m0_raddr,
  output logic          o_m1_re,
  output logic [AW-1:0] o_m1_raddr,
  input  cplx_t         i_m0_rdata,
  input  cplx_t         i_m1_rdata,
  output logic          o_bf_vld,
  output cplx_t         o_bf_x0,
  output cplx_t         o_bf_x1,
  input  logic          i_bf_vld,
  input  cplx_t         i_bf_y0,
  input  cplx_t         i_bf_y1,
  output logic          o_m0_we,
  output logic [AW-1:0] o_m0_waddr,
  output cplx_t         o_m0_wdata,
  output logic          o_m1_we,
  output logic [AW-1:0] o_m1_waddr,
  output cplx_t         o_m1_wdata,
  output logic          o_done,
  output logic          o_ovf,
  output logic          o_unf,
  output logic          o_idle
);
  localparam int CW = $clog2(TAG_D + 1);

  logic             iss_vld;
  logic             iss_sel;
  logic             rd_vld;
  logic             rd_sel;
  logic             wb_vld;
  logic [WBC_W-1:0] wb_cnt;

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop_ok;
  tag_t             push_tag;
  tag_t             head_tag;
  logic [CW:0]      occ;
  logic             accept;

  assign push_tag = '{a0: o_m0_raddr, a1: o_m1_raddr, sel: iss_sel};

  fft_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_D)
  ) u_tag_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .push      (iss_vld),
    .push_data (push_tag),
    .pop       (i_bf_vld),
    .pop_ok    (pop_ok),
    .pop_data  (head_tag),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The tag of last cycle's strobe is pushed this cycle, so it already owns a
  // slot; counting it here is what stops a back-to-back strobe from landing in
  // a FIFO that will be full by the time its own push happens.
  assign occ    = {1'b0, fifo_count} + (CW+1)'(iss_vld) - (CW+1)'(pop_ok);
  assign accept = i_addr_vld && (occ < (CW+1)'(TAG_D));

  assign o_m0_re = iss_vld;
  assign o_m1_re = iss_vld;
  assign o_m0_we = wb_vld;
  assign o_m1_we = wb_vld;
  assign o_idle  = fifo_empty && !iss_vld && !rd_vld && !o_bf_vld;

  // Issue stage and overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      iss_vld    <= 1'b0;
      iss_sel    <= 1'b0;
      o_m0_raddr <= '0;
      o_m1_raddr <= '0;
      o_ovf      <= 1'b0;
    end else begin
      iss_vld <= accept;
      if (accept) begin
        o_m0_raddr <= i_a0;
        o_m1_raddr <= i_a1;
        iss_sel    <= i_sel_wing;
      end
      if (i_addr_vld && !accept) begin
        o_ovf <= 1'b1;
      end
    end
  end

  // sel rides its own delay line alongside the read so the crossbar sees it
  // the cycle the bank data comes back, independent of FIFO pops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_vld   <= 1'b0;
      rd_sel   <= 1'b0;
      o_bf_vld <= 1'b0;
      o_bf_x0  <= '0;
      o_bf_x1  <= '0;
    end else begin
      rd_vld   <= iss_vld;
      rd_sel   <= iss_sel;
      o_bf_vld <= rd_vld;
      if (rd_vld) begin
        o_bf_x0 <= rd_sel ? i_m1_rdata : i_m0_rdata;
        o_bf_x1 <= rd_sel ? i_m0_rdata : i_m1_rdata;
      end
    end
  end

  // Write-back: each result goes back where its operands came from, so the
  // upper-wing result follows sel into whichever bank held the upper wing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_vld     <= 1'b0;
      o_m0_waddr <= '0;
      o_m1_waddr <= '0;
      o_m0_wdata <= '0;
      o_m1_wdata <= '0;
      o_done     <= 1'b0;
      o_unf      <= 1'b0;
      wb_cnt     <= '0;
    end else begin
      wb_vld <= pop_ok;
      o_done <= 1'b0;
      if (pop_ok) begin
        o_m0_waddr <= head_tag.a0;
        o_m1_waddr <= head_tag.a1;
        o_m0_wdata <= head_tag.sel ? i_bf_y1 : i_bf_y0;
        o_m1_wdata <= head_tag.sel ? i_bf_y0 : i_bf_y1;
        if (wb_cnt == WBC_W'(WB_TOTAL - 1)) begin
          wb_cnt <= '0;
          o_done <= 1'b1;
        end else begin
          wb_cnt <= wb_cnt + 1'b1;
        end
      end
      if (i_bf_vld && !pop_ok) begin
        o_unf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fft_bank_ctrl.sv
// tb/tb_fft_bank_ctrl.sv - self-checking bench for fft_bank_ctrl
module tb_fft_bank_ctrl;
  import fft_pkg::*;

  localparam int LAT = 6;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_addr_vld;
  logic [AW-1:0] i_a0, i_a1;
  logic          i_sel_wing;
  logic          o_m0_re, o_m1_re;
  logic [AW-1:0] o_m0_raddr, o_m1_raddr;
  cplx_t         i_m0_rdata, i_m1_rdata;
  logic          o_bf_vld;
  cplx_t         o_bf_x0, o_bf_x1;
  logic          i_bf_vld;
  cplx_t         i_bf_y0, i_bf_y1;
  logic          o_m0_we, o_m1_we;
  logic [AW-1:0] o_m0_waddr, o_m1_waddr;
  cplx_t         o_m0_wdata, o_m1_wdata;
  logic          o_done, o_ovf, o_unf, o_idle;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  fft_bank_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_addr_vld(i_addr_vld), .i_a0(i_a0), .i_a1(i_a1), .i_sel_wing(i_sel_wing),
    .o_m0_re(o_m0_re), .o_m0_raddr(o_m0_raddr),
    .o_m1_re(o_m1_re), .o_m1_raddr(o_m1_raddr),
    .i_m0_rdata(i_m0_rdata), .i_m1_rdata(i_m1_rdata),
    .o_bf_vld(o_bf_vld), .o_bf_x0(o_bf_x0), .o_bf_x1(o_bf_x1),
    .i_bf_vld(i_bf_vld), .i_bf_y0(i_bf_y0), .i_bf_y1(i_bf_y1),
    .o_m0_we(o_m0_we), .o_m0_waddr(o_m0_waddr), .o_m0_wdata(o_m0_wdata),
    .o_m1_we(o_m1_we), .o_m1_waddr(o_m1_waddr), .o_m1_wdata(o_m1_wdata),
    .o_done(o_done), .o_ovf(o_ovf), .o_unf(o_unf), .o_idle(o_idle)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bank environment: simple dual-port RAMs with one-cycle read latency.
  cplx_t mem0 [HALF];
  cplx_t mem1 [HALF];
  cplx_t ld0  [HALF];
  cplx_t ld1  [HALF];
  logic  ld_en = 1'b0;

  always @(posedge i_clk) begin
    if (ld_en) begin
      for (int i = 0; i < HALF; i++) begin
        mem0[i] <= ld0[i];
        mem1[i] <= ld1[i];
      end
    end else begin
      if (o_m0_we) mem0[o_m0_waddr] <= o_m0_wdata;
      if (o_m1_we) mem1[o_m1_waddr] <= o_m1_wdata;
    end
    if (o_m0_re) i_m0_rdata <= mem0[o_m0_raddr];
    if (o_m1_re) i_m1_rdata <= mem1[o_m1_raddr];
  end

  // Butterfly environment: fixed latency, y0 = x0 + x1, y1 = x0 - x1.
  logic  bf_auto = 1'b0;
  logic  auto_vld = 1'b0, man_vld;
  cplx_t auto_y0 = '0, auto_y1 = '0, man_y0, man_y1;
  assign i_bf_vld = bf_auto ? auto_vld : man_vld;
  assign i_bf_y0  = bf_auto ? auto_y0  : man_y0;
  assign i_bf_y1  = bf_auto ? auto_y1  : man_y1;

  int    cyc = 0;
  int    due_q [$];
  cplx_t y0_q [$], y1_q [$];
  cplx_t exp_x0_q [$], exp_x1_q [$];
  int    we_cnt = 0, done_cnt = 0, done_at = 0;

  always @(negedge i_clk) begin
    cyc++;
    auto_vld = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      auto_vld = 1'b1;
      auto_y0  = y0_q.pop_front();
      auto_y1  = y1_q.pop_front();
    end
    if (bf_auto && o_bf_vld) begin
      if (exp_x0_q.size() == 0) begin
        chk("bf_unexpected", 1, 0);
      end else begin
        chk("run_x0", o_bf_x0, exp_x0_q.pop_front());
        chk("run_x1", o_bf_x1, exp_x1_q.pop_front());
      end
      due_q.push_back(cyc + LAT);
      y0_q.push_back(o_bf_x0 + o_bf_x1);
      y1_q.push_back(o_bf_x0 - o_bf_x1);
    end
    if (i_rst) begin
      we_cnt = 0; done_cnt = 0; done_at = 0;
    end else begin
      if (o_m0_we) we_cnt++;
      if (o_done) begin
        done_cnt++;
        done_at = we_cnt;
      end
    end
  end

  task automatic tick();
    @(negedge i_clk);
  endtask

  // Golden memory image: updated straight from the in-place rule.
  cplx_t ref0 [HALF];
  cplx_t ref1 [HALF];

  task automatic preload();
    for (int i = 0; i < HALF; i++) begin
      ld0[i] = $urandom; ld1[i] = $urandom;
      ref0[i] = ld0[i];  ref1[i] = ld1[i];
    end
    ld_en = 1'b1;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

  initial begin
    cplx_t ya, yb, ex0, ex1;
    int    rd_cnt;
    int    t_a0 [5], t_a1 [5], t_sel [5];
    int    p0 [HALF], p1 [HALF];
    int    ra0 [$], ra1 [$];
    bit    reached;

    i_rst = 1'b1; i_addr_vld = 1'b0; i_a0 = '0; i_a1 = '0; i_sel_wing = 1'b0;
    man_vld = 1'b0; man_y0 = '0; man_y1 = '0;
    repeat (3) tick();

    chk("rst_re", {o_m0_re, o_m1_re}, 0);
    chk("rst_we", {o_m0_we, o_m1_we}, 0);
    chk("rst_bf_vld", o_bf_vld, 0);
    chk("rst_flags", {o_done, o_ovf, o_unf}, 0);
    chk("rst_idle", o_idle, 1);
    i_rst = 1'b0;
    preload();

    // Single op, sel=0: a0=3, a1=5.
    i_addr_vld = 1'b1; i_a0 = 3; i_a1 = 5; i_sel_wing = 1'b0;
    tick();
    i_addr_vld = 1'b0;
    chk("op0_re", {o_m0_re, o_m1_re}, 2'b11);
    chk("op0_raddr", {o_m0_raddr, o_m1_raddr}, {4'd3, 4'd5});
    chk("op0_busy", o_idle, 0);
    tick();
    chk("op0_bf_early", o_bf_vld, 0);
    tick();
    chk("op0_bf_vld", o_bf_vld, 1);
    chk("op0_x0", o_bf_x0, ref0[3]);
    chk("op0_x1", o_bf_x1, ref1[5]);
    ya = $urandom; yb = $urandom;
    man_vld = 1'b1; man_y0 = ya; man_y1 = yb;
    tick();
    man_vld = 1'b0;
    chk("op0_we", {o_m0_we, o_m1_we}, 2'b11);
    chk("op0_waddr", {o_m0_waddr, o_m1_waddr}, {4'd3, 4'd5});
    tick();
    chk("op0_mem0", mem0[3], ya);
    chk("op0_mem1", mem1[5], yb);
    chk("op0_idle", o_idle, 1);
    ref0[3] = ya; ref1[5] = yb;

    // Single op, sel=1: a0=2, a1=7.
    i_addr_vld = 1'b1; i_a0 = 2; i_a1 = 7; i_sel_wing = 1'b1;
    tick();
    i_addr_vld = 1'b0;
    tick();
    tick();
    chk("op1_bf_vld", o_bf_vld, 1);
    chk("op1_x0", o_bf_x0, ref1[7]);
    chk("op1_x1", o_bf_x1, ref0[2]);
    ya = $urandom; yb = $urandom;
    man_vld = 1'b1; man_y0 = ya; man_y1 = yb;
    tick();
    man_vld = 1'b0;
    chk("op1_wdata0", o_m0_wdata, yb);
    chk("op1_wdata1", o_m1_wdata, ya);
    tick();
    chk("op1_mem1", mem1[7], ya);
    chk("op1_mem0", mem0[2], yb);

    // Underflow, then reset with two tags in flight.
    do_reset();
    man_vld = 1'b1;
    tick();
    man_vld = 1'b0;
    chk("unf_no_we", o_m0_we | o_m1_we, 0);
    chk("unf_flag", o_unf, 1);
    i_addr_vld = 1'b1; i_a0 = 1; i_a1 = 4; i_sel_wing = 1'b0;
    tick();
    i_a0 = 6; i_a1 = 9;
    tick();
    i_addr_vld = 1'b0;
    tick();
    chk("fly_busy", o_idle, 0);
    i_rst = 1'b1;
    tick();
    chk("rst_fly_idle", o_idle, 1);
    chk("rst_fly_flags", {o_ovf, o_unf}, 0);
    i_rst = 1'b0;
    tick();
    man_vld = 1'b1;
    tick();
    man_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_fly_no_we", o_m0_we | o_m1_we, 0);
      tick();
    end

    // Overflow: 5 back-to-back strobes with the butterfly stalled.
    do_reset();
    rd_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      t_a0[k] = $urandom_range(HALF - 1); t_a1[k] = $urandom_range(HALF - 1);
      t_sel[k] = $urandom_range(1);
      i_addr_vld = 1'b1; i_a0 = AW'(t_a0[k]); i_a1 = AW'(t_a1[k]); i_sel_wing = t_sel[k][0];
      tick();
      if (o_m0_re) begin
        rd_cnt++;
        ra0.push_back(int'(o_m0_raddr));
        ra1.push_back(int'(o_m1_raddr));
      end
    end
    i_addr_vld = 1'b0;
    tick();
    if (o_m0_re) rd_cnt++;
    chk("ovf_reads", rd_cnt, 4);
    chk("ovf_flag", o_ovf, 1);
    for (int k = 0; k < 4 && k < ra0.size(); k++) begin
      chk("ovf_raddr", {ra0[k], ra1[k]}, {t_a0[k], t_a1[k]});
    end
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      ya = $urandom; yb = $urandom;
      man_vld = 1'b1; man_y0 = ya; man_y1 = yb;
      tick();
      man_vld = 1'b0;
      chk("ovf_we", {o_m0_we, o_m1_we}, 2'b11);
      chk("ovf_waddr", {o_m0_waddr, o_m1_waddr}, {AW'(t_a0[k]), AW'(t_a1[k])});
      chk("ovf_wdata", {o_m0_wdata, o_m1_wdata}, t_sel[k] ? {yb, ya} : {ya, yb});
    end
    tick();
    chk("ovf_idle", o_idle, 1);
    chk("ovf_no_unf", o_unf, 0);

    // Full 32-point run, R passes of random in-place schedules.
    do_reset();
    preload();
    bf_auto = 1'b1;
    for (int p = 0; p < R; p++) begin
      for (int i = 0; i < HALF; i++) begin p0[i] = i; p1[i] = i; end
      for (int i = HALF - 1; i > 0; i--) begin
        int j, t;
        j = $urandom_range(i); t = p0[i]; p0[i] = p0[j]; p0[j] = t;
        j = $urandom_range(i); t = p1[i]; p1[i] = p1[j]; p1[j] = t;
      end
      for (int k = 0; k < HALF; k++) begin
        int s;
        s = $urandom_range(1);
        ex0 = s ? ref1[p1[k]] : ref0[p0[k]];
        ex1 = s ? ref0[p0[k]] : ref1[p1[k]];
        exp_x0_q.push_back(ex0);
        exp_x1_q.push_back(ex1);
        if (s == 0) begin
          ref0[p0[k]] = ex0 + ex1; ref1[p1[k]] = ex0 - ex1;
        end else begin
          ref1[p1[k]] = ex0 + ex1; ref0[p0[k]] = ex0 - ex1;
        end
        i_addr_vld = 1'b1; i_a0 = AW'(p0[k]); i_a1 = AW'(p1[k]); i_sel_wing = s[0];
        tick();
        i_addr_vld = 1'b0;
        repeat (2) tick();
      end
      reached = 1'b0;
      for (int w = 0; w < 100 && !reached; w++) begin
        tick();
        if (o_idle && due_q.size() == 0) reached = 1'b1;
      end
      chk("pass_drain", reached, 1);
      repeat (2) tick();
    end
    bf_auto = 1'b0;
    chk("run_we_count", we_cnt, WB_TOTAL);
    chk("run_done_count", done_cnt, 1);
    chk("run_done_at", done_at, WB_TOTAL);
    chk("run_exp_left", exp_x0_q.size(), 0);
    chk("run_flags", {o_ovf, o_unf}, 0);
    for (int i = 0; i < HALF; i++) begin
      chk("run_mem0", mem0[i], ref0[i]);
      chk("run_mem1", mem1[i], ref1[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
